// File: rtl/mine_pkg.sv
// Shared constants and types for the 5x5 mine-count scanner.
package mine_pkg;

    localparam int ROWS  = 5;
    localparam int COLS  = 5;
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = 5;
    localparam int CNT_W = 4;

    typedef logic [IDX_W-1:0] cell_idx_t;
    typedef logic [CELLS-1:0] mine_map_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam cell_idx_t LAST_IDX = cell_idx_t'(CELLS - 1);

endpackage

// File: rtl/mine_neighbor_count.sv
// Combinational count of mined neighbours around one cell of the board.
// Off-board neighbours are masked per row and column, so there is no wrap between rows.
module mine_neighbor_count
    import mine_pkg::*;
(
    input  mine_map_t        i_map,
    input  cell_idx_t        i_idx,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(COLS - 1);

    logic [2:0]       w_row;
    logic [2:0]       w_col;
    logic [8:0]       w_hit;
    logic [CNT_W-1:0] w_sum;

    assign w_row = 3'(int'(i_idx) / COLS);
    assign w_col = 3'(int'(i_idx) % COLS);

    // Slot gi covers offset (gi/3-1, gi%3-1); slot 4 is the cell itself.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_nb
            localparam int DR = gi / 3 - 1;
            localparam int DC = gi % 3 - 1;
            if (gi == 4) begin : g_self
                assign w_hit[gi] = 1'b0;
            end else begin : g_cell
                logic      w_row_ok;
                logic      w_col_ok;
                cell_idx_t w_nidx;

                assign w_row_ok = (DR < 0) ? (w_row != 3'd0) :
                                  ((DR > 0) ? (w_row != LAST_ROW) : 1'b1);
                assign w_col_ok = (DC < 0) ? (w_col != 3'd0) :
                                  ((DC > 0) ? (w_col != LAST_COL) : 1'b1);
                assign w_nidx   = IDX_W'(int'(i_idx) + DR * COLS + DC);
                assign w_hit[gi] = w_row_ok & w_col_ok & i_map[w_nidx];
            end
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + CNT_W'(w_hit[k]);
        end
    end

    assign o_count = w_sum;

endmodule

// File: rtl/mine_count_scan.sv
// Snapshots a 25-bit mine map on start and streams {index, is_mine, neighbour count}
// for every cell over valid/ready. Define MINE_TOTAL_EN to add the out_total popcount port.
module mine_count_scan
    import mine_pkg::*;
(
    input  logic             in_clka,
    input  logic             in_reset,
    input  logic             in_start,
    input  logic [CELLS-1:0] in_mines,
    input  logic             in_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic             out_is_mine,
    output logic [CNT_W-1:0] out_count,
    output logic             out_busy,
    output logic             out_done
`ifdef MINE_TOTAL_EN
    ,
    output logic [IDX_W-1:0] out_total
`endif
);

    scan_state_t      r_state;
    mine_map_t        r_snap;
    cell_idx_t        r_index;
    logic             r_valid;
    logic             r_is_mine;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;

    scan_state_t      w_state_next;
    mine_map_t        w_snap_next;
    cell_idx_t        w_index_next;
    logic             w_valid_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic [CNT_W-1:0] w_count_next;

    always_comb begin
        w_state_next = r_state;
        w_snap_next  = r_snap;
        w_index_next = r_index;
        w_valid_next = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                // in_mines is only looked at here, so X outside a start never propagates.
                if (in_start) begin
                    w_state_next = SCAN;
                    w_snap_next  = in_mines;
                    w_index_next = '0;
                    w_valid_next = 1'b1;
                    w_busy_next  = 1'b1;
                end
            end
            SCAN: begin
                w_valid_next = 1'b1;
                w_busy_next  = 1'b1;
                if (in_ready) begin
                    if (r_index == LAST_IDX) begin
                        w_state_next = DONE;
                        w_valid_next = 1'b0;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_index_next = r_index + 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Count is evaluated on the next-cycle map/index so the beat registers line up.
    mine_neighbor_count u_count (
        .i_map   (w_snap_next),
        .i_idx   (w_index_next),
        .o_count (w_count_next)
    );

    always_ff @(negedge in_clka or posedge in_reset) begin
        if (in_reset) begin
            r_state   <= IDLE;
            r_snap    <= '0;
            r_index   <= '0;
            r_valid   <= 1'b0;
            r_is_mine <= 1'b0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_snap    <= w_snap_next;
            r_index   <= w_index_next;
            r_valid   <= w_valid_next;
            r_is_mine <= w_snap_next[w_index_next];
            r_count   <= w_count_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

`ifdef MINE_TOTAL_EN
    logic [IDX_W-1:0] r_total;

    always_ff @(negedge in_clka or posedge in_reset) begin
        if (in_reset) begin
            r_total <= '0;
        end else if (r_state == IDLE && in_start) begin
            r_total <= IDX_W'($countones(in_mines));
        end
    end

    assign out_total = r_total;
`endif

    assign out_valid   = r_valid;
    assign out_index   = r_index;
    assign out_is_mine = r_is_mine;
    assign out_count   = r_count;
    assign out_busy    = r_busy;
    assign out_done    = r_done;

endmodule

// File: tb/tb_mine_count_scan.sv
// Randomised bench for mine_count_scan: each beat is compared with a board-geometry model.
module tb_mine_count_scan;

    logic        in_clka = 1'b0;
    logic        in_reset = 1'b1;
    logic        in_start = 1'b0;
    logic [24:0] in_mines = '0;
    logic        in_ready = 1'b1;
    logic        out_valid;
    logic [4:0]  out_index;
    logic        out_is_mine;
    logic [3:0]  out_count;
    logic        out_busy;
    logic        out_done;
`ifdef MINE_TOTAL_EN
    logic [4:0]  out_total;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 in_clka = ~in_clka;

    mine_count_scan dut (
        .in_clka     (in_clka),
        .in_reset    (in_reset),
        .in_start    (in_start),
        .in_mines    (in_mines),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_index   (out_index),
        .out_is_mine (out_is_mine),
        .out_count   (out_count),
        .out_busy    (out_busy),
        .out_done    (out_done)
`ifdef MINE_TOTAL_EN
        ,
        .out_total   (out_total)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: count mines on the 5x5 grid around (r,c), skipping off-board cells.
    function automatic int exp_count(input logic [24:0] m, input int idx);
        int r = idx / 5;
        int c = idx % 5;
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr == 0 && dc == 0) continue;
                if (r + dr < 0 || r + dr > 4 || c + dc < 0 || c + dc > 4) continue;
                n += int'(m[(r + dr) * 5 + (c + dc)]);
            end
        end
        return n;
    endfunction

    // Called and returns at a posedge; DUT updates on negedge so posedge sampling is safe.
    task automatic run_scan(input logic [24:0] map, input int stall_at, input int start_at,
                            input int reset_at, input bit rand_ready);
        int   e      = 0;
        int   stalls = 0;
        int   cyc    = 0;
        logic hs;
        in_mines = map;
        in_start = 1'b1;
        in_ready = 1'b1;
        @(posedge in_clka);
        in_start = 1'b0;
        in_mines = 25'($urandom);
        while (e < 25 && cyc < 400) begin
            cyc++;
            check("valid", out_valid, 1);
            check("busy", out_busy, 1);
            check("done_mid", out_done, 0);
            check("index", out_index, e);
            check("is_mine", out_is_mine, map[e]);
            check("count", out_count, exp_count(map, e));
`ifdef MINE_TOTAL_EN
            check("total", out_total, $countones(map));
`endif
            if (e == reset_at) begin
                in_reset = 1'b1;
                #1;
                check("rst_valid", out_valid, 0);
                check("rst_busy", out_busy, 0);
                @(posedge in_clka);
                check("rst_done", out_done, 0);
                in_reset = 1'b0;
                in_ready = 1'b1;
                @(posedge in_clka);
                check("rst_done2", out_done, 0);
                check("rst_valid2", out_valid, 0);
                $display("scan map=%07h aborted by reset at index %0d", map, e);
                return;
            end
            in_start = (e == start_at);
            in_mines = 25'($urandom);
            hs = 1'b1;
            if (e == stall_at && stalls < 3) begin
                hs = 1'b0;
                stalls++;
            end else if (rand_ready && $urandom_range(3) == 0) begin
                hs = 1'b0;
            end
            in_ready = hs;
            @(posedge in_clka);
            if (hs) begin
                $display("beat idx=%0d mine=%0d cnt=%0d", e, map[e], exp_count(map, e));
                e++;
            end
        end
        in_start = 1'b0;
        in_ready = 1'b1;
        check("beats_done", e, 25);
        check("end_valid", out_valid, 0);
        check("end_busy", out_busy, 0);
        check("done_pulse", out_done, 1);
        @(posedge in_clka);
        check("done_clear", out_done, 0);
        check("idle_busy", out_busy, 0);
        check("idle_valid", out_valid, 0);
        if (stall_at >= 0) check("stall_cycles", stalls, 3);
        $display("scan map=%07h complete", map);
    endtask

    initial begin
        @(posedge in_clka);
        check("reset_valid", out_valid, 0);
        check("reset_busy", out_busy, 0);
        check("reset_done", out_done, 0);
        check("reset_index", out_index, 0);
        check("reset_count", out_count, 0);
        check("reset_is_mine", out_is_mine, 0);
`ifdef MINE_TOTAL_EN
        check("reset_total", out_total, 0);
`endif
        in_reset = 1'b0;
        @(posedge in_clka);
        check("idle_valid0", out_valid, 0);

        run_scan(25'h0000000, -1, -1, -1, 1'b0);
        run_scan(25'h1FFFFFF, -1, -1, -1, 1'b0);
        run_scan(25'h0001000, -1, -1, -1, 1'b0);
        run_scan(25'h0000010, -1, -1, -1, 1'b0);
        run_scan(25'($urandom), 7, -1, -1, 1'b0);
        run_scan(25'h0001011, -1, 5, -1, 1'b0);
        run_scan(25'($urandom), -1, -1, 10, 1'b0);
        run_scan(25'h0000010, -1, -1, -1, 1'b0);
        for (int t = 0; t < 4; t++) begin
            run_scan(25'($urandom), -1, 3 + t, -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
